frame_serializer: RTL and testbench

Parametrised MSB-first frame serializer for the SPI-side transmit path. It accepts a payload word, builds a frame of `{PREAMBLE, payload, CRC}`, and shifts it out one bit per programmable bit period. The CRC comes either from an external input or from an internal serial CRC-16-CCITT engine. It uses a valid/ready load handshake, supports abort, and signals frame completion with a done pulse. It sits between the payload/CRC producer in the sys_clk domain and the serial line driver.

---
 rtl/frame_pkg.sv | 35 +++
 rtl/crc16_serial.sv | 40 ++++
 rtl/frame_serializer.sv | 182 ++++++++++++++++++
 tb/tb_frame_serializer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// -----------------------------------------------------------------------------
// frame_pkg
// Shared definitions for the frame serializer transmit path and any receiver
// that needs to rebuild the same frame or check its CRC.
//   state_t          : serializer FSM states
//   CRC16_POLY/INIT  : CRC-16-CCITT constants (no reflection, no final XOR)
//   DEFAULT_PREAMBLE : preamble/SFD sent ahead of every payload
//   frame_w()        : total frame width in bits
//   crc16_step()     : one MSB-first CRC-16 update with a single data bit
// -----------------------------------------------------------------------------
package frame_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [15:0] CRC16_POLY       = 16'h1021;
    localparam logic [15:0] CRC16_INIT       = 16'hFFFF;
    localparam logic [23:0] DEFAULT_PREAMBLE = 24'h55557A;

    function automatic int frame_w(input int preamble_w, input int payload_w, input int crc_w);
        return preamble_w + payload_w + crc_w;
    endfunction

    // Shift the register left and fold the polynomial in when the bit leaving
    // the top differs from the incoming data bit.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
        logic feedback;
        feedback = crc[15] ^ bit_in;
        return {crc[14:0], 1'b0} ^ (feedback ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/crc16_serial.sv
// -----------------------------------------------------------------------------
// crc16_serial
// Bit-serial CRC-16-CCITT engine (poly 0x1021, MSB-first). Used by the
// serializer to build the CRC field and usable by a receiver for checking.
//   clk    : clock
//   reset  : asynchronous, active-low
//   init   : load CRC16_INIT (takes priority over en)
//   en     : absorb bit_in this cycle
//   bit_in : data bit
//   crc    : current CRC register
// -----------------------------------------------------------------------------
module crc16_serial
    import frame_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        init,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] crc
);

    logic [15:0] crc_r;

    // CRC register: seed on init, fold one bit per enabled cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            crc_r <= 16'h0000;
        end else if (init) begin
            crc_r <= CRC16_INIT;
        end else if (en) begin
            crc_r <= crc16_step(crc_r, bit_in);
        end else begin
            crc_r <= crc_r;
        end
    end

    assign crc = crc_r;

endmodule

// File: rtl/frame_serializer.sv
// -----------------------------------------------------------------------------
// frame_serializer
// MSB-first serializer for {PREAMBLE, payload, CRC} frames, one bit every
// bit_div+1 cycles. CRC is taken from data_crc or computed on the fly.
//   sys_clk, reset        : clock, asynchronous active-low reset
//   load_valid/load_ready : frame request handshake (ready only in IDLE)
//   data_payload, data_crc, bit_div : sampled when the request is accepted
//   abort                 : drop the frame in progress (ignored outside SHIFT)
//   serial_out            : serial data, 0 when not shifting
//   bit_tick              : high on the first cycle of every bit
//   busy                  : high while frame bits are on the line
//   serial_done_tick      : one-cycle pulse after the last bit
// -----------------------------------------------------------------------------
module frame_serializer
    import frame_pkg::*;
#(
    parameter int                    PAYLOAD_W    = 32,
    parameter int                    CRC_W        = 16,
    parameter int                    PREAMBLE_W   = 24,
    parameter logic [PREAMBLE_W-1:0] PREAMBLE     = DEFAULT_PREAMBLE,
    parameter int                    DIV_W        = 8,
    parameter bit                    CRC_INTERNAL = 1'b0
) (
    input  logic                 sys_clk,
    input  logic                 reset,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [PAYLOAD_W-1:0] data_payload,
    input  logic [CRC_W-1:0]     data_crc,
    input  logic [DIV_W-1:0]     bit_div,
    input  logic                 abort,
    output logic                 serial_out,
    output logic                 bit_tick,
    output logic                 busy,
    output logic                 serial_done_tick
);

    localparam int FRAME_W = frame_w(PREAMBLE_W, PAYLOAD_W, CRC_W);
    localparam int CNT_W   = $clog2(FRAME_W);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);
    // The bit ending at PAY_PRE starts the first payload bit; the bit ending
    // at PAY_LAST is the last payload bit, after which the CRC field follows.
    localparam logic [CNT_W-1:0] PAY_PRE  = CNT_W'(PREAMBLE_W - 1);
    localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(PREAMBLE_W + PAYLOAD_W - 1);

    localparam logic [DIV_W-1:0]   DIV_ZERO   = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0]   DIV_ONE    = DIV_W'(1);
    localparam logic [FRAME_W-1:0] FRAME_ZERO = {FRAME_W{1'b0}};

    state_t             state_r;
    logic [FRAME_W-1:0] frame_r;
    logic [DIV_W-1:0]   div_r;
    logic [DIV_W-1:0]   div_cnt_r;
    logic [CNT_W-1:0]   bit_cnt_r;
    logic               bit_tick_r;
    logic               busy_r;
    logic               done_r;

    logic               bit_end_s;
    logic [FRAME_W-1:0] frame_next_s;
    logic [CRC_W-1:0]   crc_s;

    assign bit_end_s = (div_cnt_r == div_r);

    generate
        if (CRC_INTERNAL) begin : g_crc
            logic crc_init_s;
            logic crc_en_s;
            // Seed on acceptance; absorb each payload bit on the edge that
            // starts it, so the CRC is complete before the last payload bit ends.
            assign crc_init_s = (state_r == IDLE) && load_valid;
            assign crc_en_s   = (state_r == SHIFT) && !abort && bit_end_s &&
                                (bit_cnt_r >= PAY_PRE) && (bit_cnt_r < PAY_LAST);
            crc16_serial u_crc (
                .clk    (sys_clk),
                .reset  (reset),
                .init   (crc_init_s),
                .en     (crc_en_s),
                .bit_in (frame_r[FRAME_W-2]),
                .crc    (crc_s)
            );
        end else begin : g_no_crc
            assign crc_s = {CRC_W{1'b0}};
        end
    endgenerate

    // Next frame contents at a bit boundary: plain shift, except that the
    // internally computed CRC overwrites the CRC field as it reaches the MSB.
    always_comb begin
        frame_next_s = {frame_r[FRAME_W-2:0], 1'b0};
        if (CRC_INTERNAL && (bit_cnt_r == PAY_LAST)) begin
            frame_next_s = {crc_s, {(FRAME_W-CRC_W){1'b0}}};
        end else begin
            frame_next_s = {frame_r[FRAME_W-2:0], 1'b0};
        end
    end

    // Serializer FSM with registered status outputs. serial_out is the frame
    // register MSB, which is all-zero outside SHIFT (shifted out or cleared).
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            frame_r    <= FRAME_ZERO;
            div_r      <= DIV_ZERO;
            div_cnt_r  <= DIV_ZERO;
            bit_cnt_r  <= CNT_ZERO;
            bit_tick_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (load_valid) begin
                        state_r    <= SHIFT;
                        frame_r    <= {PREAMBLE, data_payload, data_crc};
                        div_r      <= bit_div;
                        div_cnt_r  <= DIV_ZERO;
                        bit_cnt_r  <= CNT_ZERO;
                        bit_tick_r <= 1'b1;
                        busy_r     <= 1'b1;
                    end else begin
                        bit_tick_r <= 1'b0;
                        busy_r     <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        state_r    <= IDLE;
                        frame_r    <= FRAME_ZERO;
                        div_cnt_r  <= DIV_ZERO;
                        bit_cnt_r  <= CNT_ZERO;
                        bit_tick_r <= 1'b0;
                        busy_r     <= 1'b0;
                        done_r     <= 1'b0;
                    end else if (bit_end_s) begin
                        frame_r   <= frame_next_s;
                        div_cnt_r <= DIV_ZERO;
                        if (bit_cnt_r == LAST_BIT) begin
                            state_r    <= DONE;
                            bit_cnt_r  <= CNT_ZERO;
                            bit_tick_r <= 1'b0;
                            busy_r     <= 1'b0;
                            done_r     <= 1'b1;
                        end else begin
                            bit_cnt_r  <= bit_cnt_r + CNT_ONE;
                            bit_tick_r <= 1'b1;
                        end
                    end else begin
                        div_cnt_r  <= div_cnt_r + DIV_ONE;
                        bit_tick_r <= 1'b0;
                    end
                end
                DONE: begin
                    state_r    <= IDLE;
                    bit_tick_r <= 1'b0;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                end
                default: begin
                    state_r    <= IDLE;
                    frame_r    <= FRAME_ZERO;
                    div_cnt_r  <= DIV_ZERO;
                    bit_cnt_r  <= CNT_ZERO;
                    bit_tick_r <= 1'b0;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                end
            endcase
        end
    end

    assign load_ready       = (state_r == IDLE);
    assign serial_out       = frame_r[FRAME_W-1];
    assign bit_tick         = bit_tick_r;
    assign busy             = busy_r;
    assign serial_done_tick = done_r;

endmodule

// File: tb/tb_frame_serializer.sv
// -----------------------------------------------------------------------------
// tb_frame_serializer
// Two serializers share all inputs: one sends data_crc, one computes the CRC.
// Expected line activity is rebuilt per cycle from the frame timing rules.
// -----------------------------------------------------------------------------
module tb_frame_serializer;

    localparam int N = 72;
    localparam logic [9:0] IDLE_OUTS = 10'b0000010001;
    localparam logic [9:0] DONE_OUTS = 10'b0000100010;

    logic        sys_clk = 1'b0;
    logic        reset;
    logic        load_valid;
    logic        abort;
    logic [31:0] data_payload;
    logic [15:0] data_crc;
    logic [7:0]  bit_div;

    logic load_ready,   serial_out,   bit_tick,   busy,   serial_done_tick;
    logic load_ready_i, serial_out_i, bit_tick_i, busy_i, serial_done_tick_i;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] payload;
        logic [15:0] crc;
        logic [7:0]  div;
        int          lat;
        int          ticks;
    } vec_t;

    vec_t vecs[4];

    frame_serializer dut (
        .sys_clk(sys_clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
        .data_payload(data_payload), .data_crc(data_crc), .bit_div(bit_div), .abort(abort),
        .serial_out(serial_out), .bit_tick(bit_tick), .busy(busy),
        .serial_done_tick(serial_done_tick)
    );

    frame_serializer #(.CRC_INTERNAL(1'b1)) dut_i (
        .sys_clk(sys_clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready_i),
        .data_payload(data_payload), .data_crc(data_crc), .bit_div(bit_div), .abort(abort),
        .serial_out(serial_out_i), .bit_tick(bit_tick_i), .busy(busy_i),
        .serial_done_tick(serial_done_tick_i)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic step;
        @(posedge sys_clk);
        #1;
    endtask

    // CRC-16-CCITT (init FFFF) over the n low bits of 'bits', MSB-first.
    function automatic logic [15:0] crc_over(input logic [71:0] bits, input int n);
        int c;
        int fb;
        c = 32'hFFFF;
        for (int i = n - 1; i >= 0; i--) begin
            fb = ((c >> 15) & 32'h1) ^ (bits[i] ? 32'h1 : 32'h0);
            c  = (c << 1) & 32'hFFFF;
            if (fb != 0) c = c ^ 32'h1021;
        end
        return c[15:0];
    endfunction

    function automatic logic [71:0] frame_of(input logic [31:0] p, input logic [15:0] c);
        return {24'h55557A, p, c};
    endfunction

    function automatic logic [9:0] outs();
        return {serial_out, serial_out_i, bit_tick, busy, serial_done_tick, load_ready,
                bit_tick_i, busy_i, serial_done_tick_i, load_ready_i};
    endfunction

    // Present a request and return just after the accepting edge (cycle 1).
    task automatic start_frame(input logic [31:0] p, input logic [15:0] c, input logic [7:0] d,
                               input bit abort_too, output int waited);
        data_payload = p;
        data_crc     = c;
        bit_div      = d;
        load_valid   = 1'b1;
        abort        = abort_too;
        waited       = 0;
        while (!(load_ready && load_ready_i) && waited < 100) begin
            step;
            waited++;
        end
        if (waited >= 100) check("accept_timeout", 80'(load_ready), 80'd1);
        step;
        abort = 1'b0;
    endtask

    // Compare every cycle from the first bit through the done tick.
    task automatic check_frame(input logic [31:0] p, input logic [15:0] c, input logic [7:0] d,
                               input bit hold, input bit scramble,
                               output int lat, output int ticks,
                               output logic [71:0] cap_e, output logic [71:0] cap_i);
        logic [71:0] fe;
        logic [71:0] fi;
        int dd;
        int last;
        fe    = frame_of(p, c);
        fi    = frame_of(p, crc_over({40'b0, p}, 32));
        dd    = int'(d) + 1;
        last  = N * dd + 1;
        lat   = 0;
        ticks = 0;
        cap_e = 72'b0;
        cap_i = 72'b0;
        load_valid = hold;
        for (int cyc = 1; cyc <= last; cyc++) begin
            logic [9:0] want;
            int   idx;
            logic t;
            if (cyc < last) begin
                idx  = (cyc - 1) / dd;
                t    = ((cyc - 1) % dd) == 0;
                want = {fe[71-idx], fi[71-idx], t, 1'b1, 1'b0, 1'b0, t, 1'b1, 1'b0, 1'b0};
            end else begin
                want = DONE_OUTS;
            end
            check("frame_cycle", 80'(outs()), 80'(want));
            if (bit_tick) begin
                ticks++;
                cap_e = {cap_e[70:0], serial_out};
                cap_i = {cap_i[70:0], serial_out_i};
            end
            if (serial_done_tick && lat == 0) lat = cyc;
            if (cyc < last) begin
                if (scramble) begin
                    data_payload = $urandom;
                    data_crc     = 16'($urandom);
                    bit_div      = 8'($urandom);
                end
                step;
            end
        end
    endtask

    task automatic full_frame(input string tag, input logic [31:0] p, input logic [15:0] c,
                              input logic [7:0] d, input bit abort_too,
                              output logic [71:0] cap_e);
        int w;
        int lat;
        int ticks;
        logic [71:0] cap_i;
        start_frame(p, c, d, abort_too, w);
        check_frame(p, c, d, 1'b0, 1'b1, lat, ticks, cap_e, cap_i);
        check({tag, "_latency"}, 80'(lat), 80'(N * (int'(d) + 1) + 1));
        check({tag, "_ticks"}, 80'(ticks), 80'(N));
        check({tag, "_residue"}, 80'(crc_over({24'b0, cap_i[47:0]}, 48)), 80'd0);
        step;
        check({tag, "_idle_after"}, 80'(outs()), 80'(IDLE_OUTS));
    endtask

    initial begin
        int w;
        int lat;
        int ticks;
        int seen;
        logic [71:0] ce;
        logic [71:0] ci;
        logic [31:0] rp;
        logic [15:0] rc;
        logic [7:0]  rd;

        vecs[0] = '{32'hDEADBEEF, 16'hA5C3, 8'd31, 2305, 72};
        vecs[1] = '{32'hCAFEF00D, 16'h1234, 8'd15, 1153, 72};
        vecs[2] = '{32'h0F0F3C3C, 16'hFFFF, 8'd0,  73,   72};
        vecs[3] = '{32'h12345678, 16'h0000, 8'd2,  217,  72};

        reset = 1'b0; load_valid = 1'b0; abort = 1'b0;
        data_payload = 32'h0; data_crc = 16'h0; bit_div = 8'h0;
        #12;
        check("reset_state", 80'(outs()), 80'(IDLE_OUTS));
        step;
        reset = 1'b1;
        step;
        check("idle_state", 80'(outs()), 80'(IDLE_OUTS));

        // Table-driven frames.
        for (int v = 0; v < 4; v++) begin
            start_frame(vecs[v].payload, vecs[v].crc, vecs[v].div, 1'b0, w);
            check_frame(vecs[v].payload, vecs[v].crc, vecs[v].div, 1'b0, 1'b1, lat, ticks, ce, ci);
            check("vec_latency", 80'(lat), 80'(vecs[v].lat));
            check("vec_ticks", 80'(ticks), 80'(vecs[v].ticks));
            check("vec_frame", 80'(ce), 80'(frame_of(vecs[v].payload, vecs[v].crc)));
            check("vec_residue", 80'(crc_over({24'b0, ci[47:0]}, 48)), 80'd0);
            if (v == 0) begin
                check("preamble_bits", 80'(ce[71:48]), 80'(24'b010101010101010101111010));
                check("deadbeef_frame", 80'(ce), 80'(72'h55557ADEADBEEFA5C3));
            end
            step;
            check("vec_idle_after", 80'(outs()), 80'(IDLE_OUTS));
        end

        // Random frames against the model.
        repeat (4) begin
            rp = $urandom;
            rc = 16'($urandom);
            rd = 8'($urandom_range(0, 3));
            full_frame("rand", rp, rc, rd, 1'b0, ce);
            check("rand_frame", 80'(ce), 80'(frame_of(rp, rc)));
        end

        // Abort at the start of bit 40.
        start_frame(32'hA5A55A5A, 16'h0F0F, 8'd3, 1'b0, w);
        load_valid = 1'b0;
        repeat (40 * 4) step;
        check("abort_at_bit40_tick", 80'(bit_tick), 80'd1);
        abort = 1'b1;
        step;
        abort = 1'b0;
        check("abort_next", 80'(outs()), 80'(IDLE_OUTS));
        seen = 0;
        repeat (8) begin
            if (serial_done_tick || serial_done_tick_i || busy) seen = 1;
            step;
        end
        check("abort_no_done", 80'(seen), 80'd0);
        // abort together with load in IDLE: load wins.
        full_frame("after_abort", 32'h3C3CA5A5, 16'hBEEF, 8'd1, 1'b1, ce);
        check("after_abort_frame", 80'(ce), 80'(frame_of(32'h3C3CA5A5, 16'hBEEF)));

        // Reset pulled low at bit 10 for 3 cycles.
        start_frame(32'h87654321, 16'h5A5A, 8'd2, 1'b0, w);
        load_valid = 1'b0;
        repeat (10 * 3) step;
        #2;
        reset = 1'b0;
        #1;
        check("reset_async", 80'(outs()), 80'(IDLE_OUTS));
        repeat (3) step;
        check("reset_hold", 80'(outs()), 80'(IDLE_OUTS));
        reset = 1'b1;
        seen = 0;
        repeat (6) begin
            if (serial_done_tick || serial_done_tick_i || busy) seen = 1;
            step;
        end
        check("reset_no_done", 80'(seen), 80'd0);
        full_frame("after_reset", 32'h0BADF00D, 16'h1357, 8'd2, 1'b0, ce);
        check("after_reset_frame", 80'(ce), 80'(frame_of(32'h0BADF00D, 16'h1357)));

        // Back-to-back with load_valid held and inputs churning during SHIFT.
        start_frame(32'h11223344, 16'h5566, 8'd1, 1'b0, w);
        check_frame(32'h11223344, 16'h5566, 8'd1, 1'b1, 1'b1, lat, ticks, ce, ci);
        check("b2b_frame1", 80'(ce), 80'(frame_of(32'h11223344, 16'h5566)));
        check("b2b_latency1", 80'(lat), 80'd145);
        step;
        check("b2b_ready_after_done", 80'(outs()), 80'(IDLE_OUTS));
        start_frame(32'h99AABBCC, 16'hDDEE, 8'd0, 1'b0, w);
        check("b2b_gap", 80'(w), 80'd0);
        check_frame(32'h99AABBCC, 16'hDDEE, 8'd0, 1'b0, 1'b0, lat, ticks, ce, ci);
        check("b2b_frame2", 80'(ce), 80'(frame_of(32'h99AABBCC, 16'hDDEE)));
        check("b2b_latency2", 80'(lat), 80'd73);
        step;
        check("b2b_idle_after", 80'(outs()), 80'(IDLE_OUTS));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
